// File: rtl/spi_rsp_pkg.sv
// spi_rsp_pkg: shared FSM state type, synchronizer depth and SPI edge-select helper
package spi_rsp_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int SYNC_STAGES = 2;
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction
endpackage

// File: rtl/spi_rsp_sync.sv
// spi_rsp_sync: N-bit 2-flop synchronizer (clk, rstn, d in; synced q, rise/fall pulses out) with edge detect on a third stage
module spi_rsp_sync
  import spi_rsp_pkg::*;
#(
  parameter int N = 1,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);
  logic [SYNC_STAGES:0][N-1:0] pipe;
  always_ff @(posedge clk) begin
    pipe <= !rstn ? {(SYNC_STAGES + 1){RST_VAL}} : {pipe[SYNC_STAGES-1:0], d};
  end
  assign q    = pipe[SYNC_STAGES-1];
  assign rise = q & ~pipe[SYNC_STAGES];
  assign fall = ~q & pipe[SYNC_STAGES];
endmodule

// File: rtl/spi_rsp_slave.sv
// spi_rsp_slave: clk_i-oversampled SPI responder; ports: clk_i/rstn_i, spi_sck/mosi/ss_n in, spi_miso/oen out, tx valid/ready word in, rx valid/ready word out, busy/ovr/udr status; define SPI_RSP_LSB_FIRST_EN for LSB-first shifting
module spi_rsp_slave
  import spi_rsp_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0,
  parameter logic [31:0] TX_IDLE = 32'hFF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              spi_sck_i,
  input  logic              spi_mosi_i,
  input  logic              spi_ss_n_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oen_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              ovr_o,
  output logic              udr_o
);
  localparam int CW = $clog2(DATA_W);
  localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
`ifdef SPI_RSP_LSB_FIRST_EN
  localparam int OUT_BIT = 0;
`else
  localparam int OUT_BIT = DATA_W - 1;
`endif
  logic [2:0] q, rise, fall;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] hold, tx_sh, rx_sh, word, tx_nx, rx_nx;
  logic hold_full, udr_pend, active, samp, shft, ld, sh, sm, done, defer;
  logic unused_sync;
  spi_rsp_sync #(.N(3), .RST_VAL({CPOL, 2'b01})) u_sync (
    .clk (clk_i),
    .rstn(rstn_i),
    .d   ({spi_sck_i, spi_mosi_i, spi_ss_n_i}),
    .q   (q),
    .rise(rise),
    .fall(fall)
  );
  assign unused_sync = ^{q[2], q[0], rise[1], fall[1]};
  always_comb begin
    state_nx = state == IDLE ? (fall[0] ? ACTIVE : IDLE) : (rise[0] ? IDLE : ACTIVE);
    active   = state == ACTIVE && !rise[0];
    samp     = SAMPLE_RISE ? rise[2] : fall[2];
    shft     = SAMPLE_RISE ? fall[2] : rise[2];
    ld       = (state == IDLE && fall[0] && !CPHA) || (active && shft && cnt == '0);
    sh       = active && shft && cnt != '0;
    sm       = active && samp;
    done     = sm && cnt == CW'(DATA_W - 1);
    defer    = !CPHA && state == ACTIVE;
    word     = hold_full ? hold : TX_IDLE[DATA_W-1:0];
`ifdef SPI_RSP_LSB_FIRST_EN
    tx_nx    = tx_sh >> 1;
    rx_nx    = {q[1], rx_sh[DATA_W-1:1]};
`else
    tx_nx    = tx_sh << 1;
    rx_nx    = {rx_sh[DATA_W-2:0], q[1]};
`endif
  end
  always_ff @(posedge clk_i) begin
    state <= !rstn_i ? IDLE : state_nx;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt        <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      spi_miso_o <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      ovr_o      <= 1'b0;
      udr_o      <= 1'b0;
      udr_pend   <= 1'b0;
    end else begin
      if (tx_valid_i && !hold_full) hold <= tx_data_i;
      hold_full <= ld ? (!hold_full && tx_valid_i) : (hold_full || tx_valid_i);
      if (ld) begin
        tx_sh      <= word;
        spi_miso_o <= word[OUT_BIT];
      end else if (sh) begin
        tx_sh      <= tx_nx;
        spi_miso_o <= tx_nx[OUT_BIT];
      end
      if (sm) begin
        rx_sh <= rx_nx;
        cnt   <= done ? '0 : cnt + 1'b1;
      end else if (state == ACTIVE && rise[0]) begin
        cnt <= '0;
      end
      if (done && !(rx_valid_o && !rx_ready_i)) rx_data_o <= rx_nx;
      rx_valid_o <= (rx_valid_o && !rx_ready_i) || done;
      ovr_o      <= done && rx_valid_o && !rx_ready_i;
      udr_o      <= (ld && !hold_full && !defer) || (sm && udr_pend);
      udr_pend   <= ld ? (!hold_full && defer) : (udr_pend && !sm && active);
    end
  end
  assign tx_ready_o     = !hold_full;
  assign busy_o         = state == ACTIVE;
  assign spi_miso_oen_o = state == IDLE;
endmodule
